// File: rtl/control_pkg.sv
// Shared opcode/microstep encodings and the control word for the SAP-1.5 sequencer.
package control_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [2:0] T0 = 3'd0;
  localparam logic [2:0] T1 = 3'd1;
  localparam logic [2:0] T2 = 3'd2;
  localparam logic [2:0] T3 = 3'd3;
  localparam logic [2:0] T4 = 3'd4;

  typedef struct packed {
    logic pc_enable;
    logic pc_load;
    logic oe_pc;
    logic load_mar;
    logic oe_ram;
    logic ram_we;
    logic load_ir;
    logic oe_ir;
    logic load_a;
    logic oe_a;
    logic load_b;
    logic oe_alu;
    logic alu_sub;
    logic flag_enable;
    logic load_out;
  } ctrl_word_t;

endpackage

// File: rtl/control_unit_microcode_rom.sv
// Combinational microcode: (microstep, opcode, flags) -> control word, last-step and halt request.
module microcode_rom
  import control_pkg::*;
#(
  parameter int OPCODE_WIDTH = 4,
  parameter int STEP_WIDTH   = 3
) (
  input  logic [STEP_WIDTH-1:0]   step_i,
  input  logic [OPCODE_WIDTH-1:0] opcode_i,
  input  logic                    flag_carry_i,
  input  logic                    flag_zero_i,
  output ctrl_word_t              ctrl_o,
  output logic                    last_step_o,
  output logic                    halt_req_o
);

  always_comb begin
    ctrl_o      = '0;
    last_step_o = 1'b0;
    halt_req_o  = 1'b0;
    case (step_i)
      STEP_WIDTH'(T0): begin
        ctrl_o.oe_pc    = 1'b1;
        ctrl_o.load_mar = 1'b1;
      end
      STEP_WIDTH'(T1): begin
        ctrl_o.oe_ram    = 1'b1;
        ctrl_o.load_ir   = 1'b1;
        ctrl_o.pc_enable = 1'b1;
      end
      STEP_WIDTH'(T2): begin
        case (opcode_i)
          OPCODE_WIDTH'(OP_LDA), OPCODE_WIDTH'(OP_ADD),
          OPCODE_WIDTH'(OP_SUB), OPCODE_WIDTH'(OP_STA): begin
            ctrl_o.oe_ir    = 1'b1;
            ctrl_o.load_mar = 1'b1;
          end
          OPCODE_WIDTH'(OP_LDI): begin
            ctrl_o.oe_ir  = 1'b1;
            ctrl_o.load_a = 1'b1;
            last_step_o   = 1'b1;
          end
          OPCODE_WIDTH'(OP_JMP): begin
            ctrl_o.oe_ir   = 1'b1;
            ctrl_o.pc_load = 1'b1;
            last_step_o    = 1'b1;
          end
          OPCODE_WIDTH'(OP_JC): begin
            ctrl_o.oe_ir   = flag_carry_i;
            ctrl_o.pc_load = flag_carry_i;
            last_step_o    = 1'b1;
          end
          OPCODE_WIDTH'(OP_JZ): begin
            ctrl_o.oe_ir   = flag_zero_i;
            ctrl_o.pc_load = flag_zero_i;
            last_step_o    = 1'b1;
          end
          OPCODE_WIDTH'(OP_OUT): begin
            ctrl_o.oe_a     = 1'b1;
            ctrl_o.load_out = 1'b1;
            last_step_o     = 1'b1;
          end
          OPCODE_WIDTH'(OP_HLT): begin
            halt_req_o  = 1'b1;
            last_step_o = 1'b1;
          end
          default: last_step_o = 1'b1;  // NOP and undefined opcodes
        endcase
      end
      STEP_WIDTH'(T3): begin
        case (opcode_i)
          OPCODE_WIDTH'(OP_LDA): begin
            ctrl_o.oe_ram = 1'b1;
            ctrl_o.load_a = 1'b1;
            last_step_o   = 1'b1;
          end
          OPCODE_WIDTH'(OP_ADD), OPCODE_WIDTH'(OP_SUB): begin
            ctrl_o.oe_ram = 1'b1;
            ctrl_o.load_b = 1'b1;
          end
          OPCODE_WIDTH'(OP_STA): begin
            ctrl_o.oe_a   = 1'b1;
            ctrl_o.ram_we = 1'b1;
            last_step_o   = 1'b1;
          end
          default: last_step_o = 1'b1;
        endcase
      end
      STEP_WIDTH'(T4): begin
        last_step_o = 1'b1;
        if (opcode_i == OPCODE_WIDTH'(OP_ADD) || opcode_i == OPCODE_WIDTH'(OP_SUB)) begin
          ctrl_o.oe_alu      = 1'b1;
          ctrl_o.load_a      = 1'b1;
          ctrl_o.flag_enable = 1'b1;
          ctrl_o.alu_sub     = (opcode_i == OPCODE_WIDTH'(OP_SUB));
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// SAP-1.5 sequencer: microstep counter, sticky halt and reset gating around the microcode ROM.
module control_unit
  import control_pkg::*;
#(
  parameter int OPCODE_WIDTH = 4,
  parameter int STEP_WIDTH   = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    flag_carry,
  input  logic                    flag_zero,
  output logic                    pc_enable,
  output logic                    pc_load,
  output logic                    oe_pc,
  output logic                    load_mar,
  output logic                    oe_ram,
  output logic                    ram_we,
  output logic                    load_ir,
  output logic                    oe_ir,
  output logic                    load_a,
  output logic                    oe_a,
  output logic                    load_b,
  output logic                    oe_alu,
  output logic                    alu_sub,
  output logic                    flag_enable,
  output logic                    load_out,
  output logic [STEP_WIDTH-1:0]   microstep,
  output logic                    instr_done,
  output logic                    halted
);

  logic [STEP_WIDTH-1:0] step_q, step_d;
  logic                  halted_q, halted_d;
  ctrl_word_t            ctrl_rom, ctrl_g;
  logic                  last_step, halt_req, active;

  microcode_rom #(
    .OPCODE_WIDTH(OPCODE_WIDTH),
    .STEP_WIDTH  (STEP_WIDTH)
  ) u_rom (
    .step_i      (step_q),
    .opcode_i    (opcode),
    .flag_carry_i(flag_carry),
    .flag_zero_i (flag_zero),
    .ctrl_o      (ctrl_rom),
    .last_step_o (last_step),
    .halt_req_o  (halt_req)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      step_q   <= '0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

  // Out-of-range steps fall back to T0; the ROM already emits no controls for them.
  always_comb begin
    step_d   = step_q;
    halted_d = halted_q;
    if (!halted_q) begin
      if (last_step || step_q > STEP_WIDTH'(T4)) step_d = STEP_WIDTH'(T0);
      else                                       step_d = step_q + STEP_WIDTH'(1);
      if (halt_req) halted_d = 1'b1;
    end
  end

  assign active     = reset && !halted_q;
  assign ctrl_g     = active ? ctrl_rom : '0;
  assign instr_done = active && last_step;
  assign microstep  = step_q;
  assign halted     = halted_q;

  assign pc_enable   = ctrl_g.pc_enable;
  assign pc_load     = ctrl_g.pc_load;
  assign oe_pc       = ctrl_g.oe_pc;
  assign load_mar    = ctrl_g.load_mar;
  assign oe_ram      = ctrl_g.oe_ram;
  assign ram_we      = ctrl_g.ram_we;
  assign load_ir     = ctrl_g.load_ir;
  assign oe_ir       = ctrl_g.oe_ir;
  assign load_a      = ctrl_g.load_a;
  assign oe_a        = ctrl_g.oe_a;
  assign load_b      = ctrl_g.load_b;
  assign oe_alu      = ctrl_g.oe_alu;
  assign alu_sub     = ctrl_g.alu_sub;
  assign flag_enable = ctrl_g.flag_enable;
  assign load_out    = ctrl_g.load_out;

  a_single_bus_driver: assert property (@(posedge clk) $onehot0({oe_pc, oe_ram, oe_ir, oe_a, oe_alu}));

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: fetch/execute decode, halt, mid-instruction reset, random invariants.
module tb_control_unit;

  localparam logic [14:0] C_PCE  = 15'h4000;
  localparam logic [14:0] C_PCL  = 15'h2000;
  localparam logic [14:0] C_OPC  = 15'h1000;
  localparam logic [14:0] C_MAR  = 15'h0800;
  localparam logic [14:0] C_ORAM = 15'h0400;
  localparam logic [14:0] C_WE   = 15'h0200;
  localparam logic [14:0] C_LIR  = 15'h0100;
  localparam logic [14:0] C_OIR  = 15'h0080;
  localparam logic [14:0] C_LA   = 15'h0040;
  localparam logic [14:0] C_OA   = 15'h0020;
  localparam logic [14:0] C_LB   = 15'h0010;
  localparam logic [14:0] C_OALU = 15'h0008;
  localparam logic [14:0] C_SUB  = 15'h0004;
  localparam logic [14:0] C_FE   = 15'h0002;
  localparam logic [14:0] C_OUT  = 15'h0001;
  localparam logic [14:0] C_F0   = C_OPC | C_MAR;
  localparam logic [14:0] C_F1   = C_ORAM | C_LIR | C_PCE;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] opcode;
  logic       flag_carry, flag_zero;
  logic       pc_enable, pc_load, oe_pc, load_mar, oe_ram, ram_we, load_ir, oe_ir;
  logic       load_a, oe_a, load_b, oe_alu, alu_sub, flag_enable, load_out;
  logic [2:0] microstep;
  logic       instr_done, halted;
  logic [14:0] ctl;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  always #5 clk = ~clk;

  control_unit dut (
    .clk(clk), .reset(reset), .opcode(opcode),
    .flag_carry(flag_carry), .flag_zero(flag_zero),
    .pc_enable(pc_enable), .pc_load(pc_load), .oe_pc(oe_pc), .load_mar(load_mar),
    .oe_ram(oe_ram), .ram_we(ram_we), .load_ir(load_ir), .oe_ir(oe_ir),
    .load_a(load_a), .oe_a(oe_a), .load_b(load_b), .oe_alu(oe_alu),
    .alu_sub(alu_sub), .flag_enable(flag_enable), .load_out(load_out),
    .microstep(microstep), .instr_done(instr_done), .halted(halted)
  );

  assign ctl = {pc_enable, pc_load, oe_pc, load_mar, oe_ram, ram_we, load_ir, oe_ir,
                load_a, oe_a, load_b, oe_alu, alu_sub, flag_enable, load_out};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tot_cnt = tot_cnt + 1;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Called one ns after a rising edge with inputs already set; checks the cycle, then advances.
  task automatic cyc(input string tag, input logic [2:0] st, input logic [14:0] c, input logic done);
    #1;
    chk({tag, ".step"}, 32'(microstep), 32'(st));
    chk({tag, ".ctl"},  32'(ctl),       32'(c));
    chk({tag, ".done"}, 32'(instr_done), 32'(done));
    @(posedge clk); #1;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; opcode = 4'h0; flag_carry = 1'b0; flag_zero = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rst.ctl",  32'(ctl), 32'h0);
      chk("rst.done", 32'(instr_done), 32'h0);
      @(posedge clk); #1;
    end
    chk("rst.step",   32'(microstep), 32'h0);
    chk("rst.halted", 32'(halted), 32'h0);
    reset = 1'b1;

    // NOP
    cyc("nop.t0", 3'd0, C_F0, 1'b0);
    cyc("nop.t1", 3'd1, C_F1, 1'b0);
    cyc("nop.t2", 3'd2, 15'h0, 1'b1);

    // ADD then SUB
    opcode = 4'h2;
    cyc("add.t0", 3'd0, C_F0, 1'b0);
    cyc("add.t1", 3'd1, C_F1, 1'b0);
    cyc("add.t2", 3'd2, C_OIR | C_MAR, 1'b0);
    cyc("add.t3", 3'd3, C_ORAM | C_LB, 1'b0);
    cyc("add.t4", 3'd4, C_OALU | C_LA | C_FE, 1'b1);
    opcode = 4'h3;
    cyc("sub.t0", 3'd0, C_F0, 1'b0);
    cyc("sub.t1", 3'd1, C_F1, 1'b0);
    cyc("sub.t2", 3'd2, C_OIR | C_MAR, 1'b0);
    cyc("sub.t3", 3'd3, C_ORAM | C_LB, 1'b0);
    cyc("sub.t4", 3'd4, C_OALU | C_LA | C_FE | C_SUB, 1'b1);

    // JC: carry high outside T2 must not matter
    opcode = 4'h7; flag_carry = 1'b1;
    cyc("jc0.t0", 3'd0, C_F0, 1'b0);
    cyc("jc0.t1", 3'd1, C_F1, 1'b0);
    flag_carry = 1'b0;
    cyc("jc0.t2", 3'd2, 15'h0, 1'b1);
    flag_carry = 1'b1;
    cyc("jc1.t0", 3'd0, C_F0, 1'b0);
    cyc("jc1.t1", 3'd1, C_F1, 1'b0);
    cyc("jc1.t2", 3'd2, C_OIR | C_PCL, 1'b1);
    flag_carry = 1'b0;

    // JZ both ways; carry set to show JZ ignores it
    opcode = 4'h8; flag_carry = 1'b1; flag_zero = 1'b0;
    cyc("jz0.t0", 3'd0, C_F0, 1'b0);
    cyc("jz0.t1", 3'd1, C_F1, 1'b0);
    cyc("jz0.t2", 3'd2, 15'h0, 1'b1);
    flag_carry = 1'b0; flag_zero = 1'b1;
    cyc("jz1.t0", 3'd0, C_F0, 1'b0);
    cyc("jz1.t1", 3'd1, C_F1, 1'b0);
    cyc("jz1.t2", 3'd2, C_OIR | C_PCL, 1'b1);
    flag_zero = 1'b0;

    // LDA, LDI, JMP, OUT, undefined
    opcode = 4'h1;
    cyc("lda.t0", 3'd0, C_F0, 1'b0);
    cyc("lda.t1", 3'd1, C_F1, 1'b0);
    cyc("lda.t2", 3'd2, C_OIR | C_MAR, 1'b0);
    cyc("lda.t3", 3'd3, C_ORAM | C_LA, 1'b1);
    opcode = 4'h5;
    cyc("ldi.t0", 3'd0, C_F0, 1'b0);
    cyc("ldi.t1", 3'd1, C_F1, 1'b0);
    cyc("ldi.t2", 3'd2, C_OIR | C_LA, 1'b1);
    opcode = 4'h6;
    cyc("jmp.t0", 3'd0, C_F0, 1'b0);
    cyc("jmp.t1", 3'd1, C_F1, 1'b0);
    cyc("jmp.t2", 3'd2, C_OIR | C_PCL, 1'b1);
    opcode = 4'hE;
    cyc("out.t0", 3'd0, C_F0, 1'b0);
    cyc("out.t1", 3'd1, C_F1, 1'b0);
    cyc("out.t2", 3'd2, C_OA | C_OUT, 1'b1);
    opcode = 4'hB;
    cyc("undef.t0", 3'd0, C_F0, 1'b0);
    cyc("undef.t1", 3'd1, C_F1, 1'b0);
    cyc("undef.t2", 3'd2, 15'h0, 1'b1);

    // STA completes normally
    opcode = 4'h4;
    cyc("sta.t0", 3'd0, C_F0, 1'b0);
    cyc("sta.t1", 3'd1, C_F1, 1'b0);
    cyc("sta.t2", 3'd2, C_OIR | C_MAR, 1'b0);
    cyc("sta.t3", 3'd3, C_OA | C_WE, 1'b1);

    // STA aborted by reset during T3
    cyc("star.t0", 3'd0, C_F0, 1'b0);
    cyc("star.t1", 3'd1, C_F1, 1'b0);
    cyc("star.t2", 3'd2, C_OIR | C_MAR, 1'b0);
    #1;
    chk("star.t3.step", 32'(microstep), 32'd3);
    chk("star.t3.ctl",  32'(ctl), 32'(C_OA | C_WE));
    reset = 1'b0;
    #1;
    chk("star.rst.ctl",  32'(ctl), 32'h0);
    chk("star.rst.we",   32'(ram_we), 32'h0);
    chk("star.rst.done", 32'(instr_done), 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    cyc("star.after", 3'd0, C_F0, 1'b0);

    // HLT
    opcode = 4'hF;
    cyc("hlt.t1", 3'd1, C_F1, 1'b0);
    chk("hlt.pre", 32'(halted), 32'h0);
    cyc("hlt.t2", 3'd2, 15'h0, 1'b1);
    opcode = 4'h2; flag_carry = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("hlt.halted", 32'(halted), 32'h1);
      chk("hlt.step",   32'(microstep), 32'h0);
      chk("hlt.ctl",    32'(ctl), 32'h0);
      chk("hlt.done",   32'(instr_done), 32'h0);
      @(posedge clk); #1;
    end
    flag_carry = 1'b0;
    reset = 1'b0;
    #1;
    chk("hlt.rst.ctl", 32'(ctl), 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("hlt.clr.halted", 32'(halted), 32'h0);
    cyc("hlt.clr", 3'd0, C_F0, 1'b0);

    // Random opcodes/flags: bus driver one-hot-or-zero, step in range, never halts
    for (int i = 0; i < 10000; i++) begin
      opcode     = 4'($urandom_range(0, 14));
      flag_carry = 1'($urandom);
      flag_zero  = 1'($urandom);
      #1;
      chk("rnd.onehot", 32'($onehot0({oe_pc, oe_ram, oe_ir, oe_a, oe_alu})), 32'h1);
      chk("rnd.range",  32'(microstep <= 3'd4), 32'h1);
      chk("rnd.halted", 32'(halted), 32'h0);
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Microcoded sequencer for the SAP-1.5 bus datapath.
- Owns the microstep counter and decodes the latched opcode, ALU flags and microstep into every load, output-enable and ALU control line.
- Sits beside the program counter, MAR, IR, RAM, A/B registers, ALU and output register, and replaces the ad-hoc sequencing in the top level.
- Exactly one bus driver (or none) per cycle, guaranteed by construction.

Parameters:
- OPCODE_WIDTH, 4, width of the opcode field from the instruction register.
- STEP_WIDTH, 3, width of the microstep counter (T0..T4 used).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- opcode  in  OPCODE_WIDTH  upper IR nibble, valid from T2 onward.
- flag_carry  in  1  registered ALU carry flag.
- flag_zero  in  1  registered ALU zero flag.
- pc_enable  out  1  PC increment.
- pc_load  out  1  PC loads from bus.
- oe_pc  out  1  PC drives bus.
- load_mar  out  1  MAR loads from bus.
- oe_ram  out  1  RAM drives bus.
- ram_we  out  1  RAM writes bus at MAR.
- load_ir  out  1  IR loads from bus.
- oe_ir  out  1  IR operand drives bus.
- load_a  out  1  A loads from bus.
- oe_a  out  1  A drives bus.
- load_b  out  1  B loads from bus.
- oe_alu  out  1  ALU result drives bus.
- alu_sub  out  1  ALU subtract select.
- flag_enable  out  1  ALU flags latch this cycle.
- load_out  out  1  output register loads from bus.
- microstep  out  STEP_WIDTH  current step, for debug.
- instr_done  out  1  high during the last step of each instruction.
- halted  out  1  sticky halt indicator.

Behaviour:
Reset and timing:
- Reset is sampled on the rising clk edge with reset==0. It sets microstep=T0 and halted=0.
- While reset==0, all control outputs are forced to 0 combinationally, and instr_done=0.
- Control outputs are a combinational decode of the registered microstep, opcode, flags and halted state. The targeted load happens at the rising edge that ends the step, so there is 1-cycle latency per step.
- microstep advances by 1 each clk. At the edge ending the instruction's last step (instr_done=1), microstep returns to T0.

Fetch (every instruction):
- T0: oe_pc, load_mar.
- T1: oe_ram, load_ir, pc_enable.

Execute, by opcode:
- 0x0 NOP: T2 no controls; last step T2.
- 0x1 LDA: T2 oe_ir+load_mar; T3 oe_ram+load_a; last step T3.
- 0x2 ADD: T2 oe_ir+load_mar; T3 oe_ram+load_b; T4 oe_alu+load_a+flag_enable; last step T4.
- 0x3 SUB: same as ADD, with alu_sub=1 in T4 only.
- 0x4 STA: T2 oe_ir+load_mar; T3 oe_a+ram_we; last step T3.
- 0x5 LDI: T2 oe_ir+load_a; last step T2.
- 0x6 JMP: T2 oe_ir+pc_load; last step T2.
- 0x7 JC: T2 oe_ir+pc_load only if flag_carry==1, otherwise no controls; last step T2.
- 0x8 JZ: as JC but using flag_zero.
- 0xE OUT: T2 oe_a+load_out; last step T2.
- 0xF HLT: T2 sets halted at the edge ending T2.
- Undefined opcodes (0x9..0xD): treated as NOP.

Halt:
- Once halted=1, microstep holds its value, all control outputs stay 0 and instr_done=0.
- Only reset clears halted.

Boundary conditions:
- Flags are sampled combinationally during T2 only. A flag change in any other step has no effect.
- At most one of {oe_pc, oe_ram, oe_ir, oe_a, oe_alu} may be high in any cycle. This is an invariant and is asserted in simulation.
- microstep values above T4 are unreachable. If reached, the next edge returns microstep to T0 and all controls are 0 for that cycle.
- Reset mid-instruction aborts it immediately. No partial state is retained in this block.

Decomposition:
- Package control_pkg holds:
  - opcode localparams (OP_NOP..OP_HLT);
  - microstep localparams T0..T4;
  - packed struct ctrl_word_t with one bit per control output.
- Sub-module microcode_rom: a combinational function of (microstep, opcode, flag_carry, flag_zero) returning ctrl_word_t and last_step.
- control_unit keeps the step counter, the halted flag and reset gating.

Test Plan:
- Reset held low 3 cycles, then released, opcode=0x0 -> all controls 0 during reset; T0 shows oe_pc=load_mar=1; T1 shows oe_ram=load_ir=pc_enable=1; T2 has instr_done=1; microstep back to 0 on the next cycle.
- opcode=0x2 (ADD) -> microstep sequence 0,1,2,3,4,0; T4 shows oe_alu=load_a=flag_enable=1, alu_sub=0. Repeat with 0x3: alu_sub=1 in T4 only.
- opcode=0x7, flag_carry=0 -> T2 has pc_load=0 and instr_done=1. Repeat with flag_carry=1 -> T2 has oe_ir=pc_load=1.
- opcode=0xF -> halted=1 after T2; the next 10 cycles show all controls 0 and microstep frozen. reset=0 for one cycle -> halted=0, microstep=0.
- opcode=0x4 (STA), reset driven low during T3 -> ram_we=0 in that cycle, microstep=0 after the edge.
- Random opcodes and flags for 10k cycles -> bus-driver one-hot-or-zero assertion never fires; microstep never exceeds 4.
